// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Bundle between the multi-cycle CPU control FSM and its datapath.
//             The controller takes the 'master' modport and the datapath (or a
//             testbench standing in for it) takes the 'slave' modport.
//  Signals  : opcode/funct (IR fields), zero (ALU flag), mem_ready (memory
//             done) flow into the controller. Datapath enables, mux selects,
//             retire/illegal pulses, the debug state and the two performance
//             counters flow out of it.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             iord;
    logic             alu_srca_sel;
    logic [1:0]       alu_srcb_sel;
    logic             imm_shl2;
    logic [1:0]       pc_src_sel;
    logic [1:0]       reg_dst_sel;
    logic [1:0]       mem_to_reg_sel;
    logic [1:0]       alu_op;
    logic             instr_done;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               reg_write, iord, alu_srca_sel, alu_srcb_sel, imm_shl2,
               pc_src_sel, reg_dst_sel, mem_to_reg_sel, alu_op,
               instr_done, illegal, state, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write,
               reg_write, iord, alu_srca_sel, alu_srcb_sel, imm_shl2,
               pc_src_sel, reg_dst_sel, mem_to_reg_sel, alu_op,
               instr_done, illegal, state, cycle_cnt, instr_cnt
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Main control FSM of the multi-cycle CPU. Steps each instruction
//             through fetch, decode, execute, memory and write-back, drives
//             the datapath enables and 2-bit mux selects (0 = middle input,
//             1 = first input, 2 = third input, 3 never driven), and keeps
//             free-running cycle and retired-instruction counters.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous reset, active high
//             bus  - multicycle_ctrl_if.master (IR fields, zero, mem_ready in;
//                    enables, selects, instr_done, illegal, state, counters
//                    out)
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    multicycle_ctrl_if.master bus
);

    // ------------------------------------------------------------------
    // State encoding (exposed on bus.state for debug)
    // ------------------------------------------------------------------
    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_FETCH  = 4'd1;
    localparam logic [3:0] c_DECODE = 4'd2;
    localparam logic [3:0] c_MEMADR = 4'd3;
    localparam logic [3:0] c_MEMRD  = 4'd4;
    localparam logic [3:0] c_MEMWB  = 4'd5;
    localparam logic [3:0] c_MEMWR  = 4'd6;
    localparam logic [3:0] c_EXEC   = 4'd7;
    localparam logic [3:0] c_RWB    = 4'd8;
    localparam logic [3:0] c_BRANCH = 4'd9;
    localparam logic [3:0] c_JUMP   = 4'd10;
    localparam logic [3:0] c_ADDIEX = 4'd11;
    localparam logic [3:0] c_ADDIWB = 4'd12;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Registered Moore outputs. They are computed from the next state so
    // that they line up with the state register in the same cycle. The
    // in_* / retire flags are qualifiers for the few outputs that also
    // depend on live inputs.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       alu_srca_sel;
        logic [1:0] alu_srcb_sel;
        logic       imm_shl2;
        logic [1:0] pc_src_sel;
        logic [1:0] reg_dst_sel;
        logic [1:0] mem_to_reg_sel;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       pc_write_cond;
        logic       jump_write;   // unconditional PC write in JUMP
        logic       in_fetch;     // gates ir_write/pc_write with mem_ready
        logic       in_decode;    // gates illegal
        logic       in_memwr;     // store retires on mem_ready
        logic       retire;       // states that always retire
    } moore_t;

    function automatic moore_t f_moore(input logic [3:0] st);
        moore_t m;
        m = '0;
        case (st)
            c_FETCH: begin
                m.mem_read     = 1'b1;
                m.alu_srcb_sel = 2'd1;
                m.in_fetch     = 1'b1;
            end
            c_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                m.alu_srcb_sel = 2'd2;
                m.imm_shl2     = 1'b1;
                m.in_decode    = 1'b1;
            end
            c_MEMADR, c_ADDIEX: begin
                m.alu_srca_sel = 1'b1;
                m.alu_srcb_sel = 2'd2;
            end
            c_MEMRD: begin
                m.mem_read = 1'b1;
                m.iord     = 1'b1;
            end
            c_MEMWR: begin
                m.mem_write = 1'b1;
                m.iord      = 1'b1;
                m.in_memwr  = 1'b1;
            end
            c_MEMWB: begin
                m.reg_write      = 1'b1;
                m.mem_to_reg_sel = 2'd1;
                m.retire         = 1'b1;
            end
            c_ADDIWB: begin
                m.reg_write = 1'b1;
                m.retire    = 1'b1;
            end
            c_EXEC: begin
                m.alu_srca_sel = 1'b1;
                m.alu_op       = 2'b10;
            end
            c_RWB: begin
                m.reg_write   = 1'b1;
                m.reg_dst_sel = 2'd1;
                m.retire      = 1'b1;
            end
            c_BRANCH: begin
                m.alu_srca_sel  = 1'b1;
                m.alu_op        = 2'b01;
                m.pc_write_cond = 1'b1;
                m.pc_src_sel    = 2'd1;
                m.retire        = 1'b1;
            end
            c_JUMP: begin
                m.jump_write = 1'b1;
                m.pc_src_sel = 2'd2;
                m.retire     = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    logic [3:0]       r_state;
    moore_t           r_out;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic [3:0]       w_next;
    logic [3:0]       w_dec_next;
    logic             w_dec_legal;
    logic             w_funct_ok;
    logic             w_fetch_done;
    logic             w_instr_done;

    assign w_funct_ok = (bus.funct == c_FN_ADD) || (bus.funct == c_FN_SUB) ||
                        (bus.funct == c_FN_AND) || (bus.funct == c_FN_OR)  ||
                        (bus.funct == c_FN_SLT);

    // Instruction decode; only meaningful while in DECODE.
    always_comb begin
        w_dec_next  = c_FETCH;
        w_dec_legal = 1'b1;
        case (bus.opcode)
            c_OP_LW, c_OP_SW: w_dec_next = c_MEMADR;
            c_OP_RTYPE: begin
                if (w_funct_ok) begin
                    w_dec_next = c_EXEC;
                end else begin
                    w_dec_legal = 1'b0;
                end
            end
            c_OP_BEQ:  w_dec_next = c_BRANCH;
            c_OP_J:    w_dec_next = c_JUMP;
            c_OP_ADDI: w_dec_next = c_ADDIEX;
            default:   w_dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   w_next = c_FETCH;
            c_FETCH:  w_next = bus.mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: w_next = w_dec_next;
            // Only lw and sw reach MEMADR, so anything but sw is a load.
            c_MEMADR: w_next = (bus.opcode == c_OP_SW) ? c_MEMWR : c_MEMRD;
            c_MEMRD:  w_next = bus.mem_ready ? c_MEMWB : c_MEMRD;
            c_MEMWR:  w_next = bus.mem_ready ? c_FETCH : c_MEMWR;
            c_EXEC:   w_next = c_RWB;
            c_ADDIEX: w_next = c_ADDIWB;
            c_MEMWB, c_RWB, c_BRANCH, c_JUMP, c_ADDIWB: w_next = c_FETCH;
            // Unused encodings fall back to a clean restart.
            default:  w_next = c_IDLE;
        endcase
    end

    assign w_fetch_done = r_out.in_fetch & bus.mem_ready;
    assign w_instr_done = r_out.retire | (r_out.in_memwr & bus.mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_out       <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_out       <= f_moore(w_next);
            r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
            if (w_instr_done) begin
                r_instr_cnt <= r_instr_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.pc_write       = r_out.jump_write | w_fetch_done;
    assign bus.pc_write_cond  = r_out.pc_write_cond;
    assign bus.ir_write       = w_fetch_done;
    assign bus.mem_read       = r_out.mem_read;
    assign bus.mem_write      = r_out.mem_write;
    assign bus.reg_write      = r_out.reg_write;
    assign bus.iord           = r_out.iord;
    assign bus.alu_srca_sel   = r_out.alu_srca_sel;
    assign bus.alu_srcb_sel   = r_out.alu_srcb_sel;
    assign bus.imm_shl2       = r_out.imm_shl2;
    assign bus.pc_src_sel     = r_out.pc_src_sel;
    assign bus.reg_dst_sel    = r_out.reg_dst_sel;
    assign bus.mem_to_reg_sel = r_out.mem_to_reg_sel;
    assign bus.alu_op         = r_out.alu_op;
    assign bus.instr_done     = w_instr_done;
    assign bus.illegal        = r_out.in_decode & ~w_dec_legal;
    assign bus.state          = r_state;
    assign bus.cycle_cnt      = r_cycle_cnt;
    assign bus.instr_cnt      = r_instr_cnt;

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle CPU. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the 2-bit select lines of the datapath's 3-input muxes using the mux select encoding: 0 picks the middle/default input, 1 picks the first input, 2 picks the third input, and 3 is never driven. It also keeps cycle and retired-instruction counters for performance checks.

## Interface
- CNT_W, 32, width of the cycle and instruction counters
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completion handshake
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath enables
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- alu_srca_sel  out  1  ALU A input: 0 = PC, 1 = A register
- alu_srcb_sel  out  2  ALU B input: 0 = B register, 1 = constant 4, 2 = extended immediate
- imm_shl2  out  1  extender shifts the immediate left by 2
- pc_src_sel  out  2  next PC: 0 = ALU result, 1 = ALUOut, 2 = jump target
- reg_dst_sel  out  2  destination register: 0 = rt, 1 = rd
- mem_to_reg_sel  out  2  write-back data: 0 = ALUOut, 1 = MDR
- alu_op  out  2  ALU function: 00 = add, 01 = sub, 10 = decode from funct
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- state  out  4  current state, for debug
- cycle_cnt, instr_cnt  out  CNT_W  performance counters

## Operation
- States and their encodings:
  - IDLE = 0
  - FETCH = 1
  - DECODE = 2
  - MEMADR = 3
  - MEMRD = 4
  - MEMWB = 5
  - MEMWR = 6
  - EXEC = 7
  - RWB = 8
  - BRANCH = 9
  - JUMP = 10
  - ADDIEX = 11
  - ADDIWB = 12
- Datapath outputs are a Moore function of `state`. Any state not named below drives 0 on every output.
- Exceptions: `instr_done` and `illegal` also depend on the inputs, as defined below.
- Outputs per state:
  - IDLE: all outputs 0.
  - FETCH: mem_read=1, iord=0, alu_srca_sel=0, alu_srcb_sel=1, alu_op=00, pc_src_sel=0. ir_write and pc_write are asserted only when mem_ready=1.
  - DECODE: alu_srca_sel=0, alu_srcb_sel=2, imm_shl2=1, alu_op=00. This precomputes the branch target into ALUOut.
  - MEMADR and ADDIEX: alu_srca_sel=1, alu_srcb_sel=2, alu_op=00.
  - MEMRD: mem_read=1, iord=1.
  - MEMWR: mem_write=1, iord=1.
  - MEMWB and ADDIWB: reg_write=1, reg_dst_sel=0. mem_to_reg_sel is 1 in MEMWB and 0 in ADDIWB.
  - EXEC: alu_srca_sel=1, alu_srcb_sel=0, alu_op=10.
  - RWB: reg_write=1, reg_dst_sel=1, mem_to_reg_sel=0.
  - BRANCH: alu_srca_sel=1, alu_srcb_sel=0, alu_op=01, pc_write_cond=1, pc_src_sel=1. The datapath writes PC when pc_write_cond and zero are both set.
  - JUMP: pc_write=1, pc_src_sel=2.
- Transitions:
  - IDLE goes to FETCH.
  - FETCH stays in FETCH while mem_ready=0, otherwise goes to DECODE.
  - DECODE branches on opcode:
    - 0x23 (lw) or 0x2B (sw): MEMADR.
    - 0x00 (R-type) with funct in {0x20, 0x22, 0x24, 0x25, 0x2A}: EXEC.
    - 0x04 (beq): BRANCH.
    - 0x02 (j): JUMP.
    - 0x08 (addi): ADDIEX.
    - anything else: FETCH, with illegal=1 for that cycle.
  - MEMADR goes to MEMRD for lw and MEMWR for sw.
  - MEMRD stays while mem_ready=0, otherwise goes to MEMWB.
  - MEMWR stays while mem_ready=0, otherwise goes to FETCH.
  - EXEC goes to RWB.
  - ADDIEX goes to ADDIWB.
  - MEMWB, RWB, BRANCH, JUMP and ADDIWB all go to FETCH.
- opcode and funct are sampled only in DECODE and MEMADR. IR is stable in those states.
- instr_done is 1 in MEMWB, RWB, BRANCH, JUMP and ADDIWB, and in MEMWR when mem_ready=1. It is never 1 in any other state.
- Counters:
  - cycle_cnt increments on every non-reset cycle, including IDLE.
  - instr_cnt increments on each cycle where instr_done=1.
  - Both are modulo 2^CNT_W: all-ones wraps to 0.
  - An illegal instruction does not increment instr_cnt.

## Timing
- Reset: when rst is sampled high, the next state is IDLE and both counters become 0. rst has priority over everything, including a pending mem_ready or a mid-instruction state.
- After reset: IDLE lasts 1 cycle, then FETCH. All datapath outputs are 0 during reset and in IDLE.
- Instruction latency with mem_ready tied to 1, counted from FETCH entry to the cycle that asserts instr_done:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. While stalled, the memory strobes stay asserted, and ir_write and pc_write stay 0.
- The next FETCH always follows the instr_done cycle directly, with no gap cycle.
- An illegal instruction costs FETCH + DECODE (2 cycles), then refetches. PC has already advanced.

## Test plan
- Reset then IDLE: assert rst for 3 cycles in the middle of an lw in MEMRD, then release. Required: state=0 with all outputs 0 and cycle_cnt=0; one cycle later state=1 and cycle_cnt=1.
- Mixed program: apply the sequence lw, sw, add (funct 0x20), addi, beq, j with mem_ready=1. Required: state sequences 1,2,3,4,5 / 1,2,3,6 / 1,2,7,8 / 1,2,11,12 / 1,2,9 / 1,2,10; instr_cnt=6 after 23 cycles from the first FETCH.
- Memory stalls: drop mem_ready for 3 cycles in FETCH and 2 cycles in MEMRD. Required: the lw takes 10 cycles; ir_write fires exactly once; reg_write fires exactly once, in MEMWB.
- Illegal instruction: opcode 0x3F, then R-type with funct 0x01. Required: illegal pulses once per instruction in DECODE; the next state is FETCH; instr_cnt is unchanged.
- Mux select encodings: in BRANCH, check pc_src_sel=1 and alu_op=01. In JUMP, check pc_src_sel=2. In DECODE, check alu_srcb_sel=2 with imm_shl2=1. The value 3 never appears on any select during random opcode streams.
- Counter wrap-around: with CNT_W=4, run 16 cycles after reset. Required: cycle_cnt goes 15 then 0, and instr_cnt wraps the same way.
